// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, word/byte-enable
// widths and the request address check.
package mem_pkg;

  localparam int DATA_SIZE    = 32;
  localparam int BYTE_EN_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A request is in error if it is not word aligned or addresses beyond the array.
  function automatic logic addr_error(input logic [31:0] addr, input int addr_size);
    logic [31:0] w_hi;
    w_hi = addr >> (addr_size + 2);
    return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array with byte write enables and a registered read port.
// Contents are intentionally not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DataW    = DATA_SIZE,
  parameter int AddrSize = 8
) (
  input  logic                    Clk,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [AddrSize-1:0]     i_addr,
  input  logic [BYTE_EN_SIZE-1:0] i_be,
  input  logic [DataW-1:0]        i_wdata,
  output logic [DataW-1:0]        o_rdata
);

  logic [DataW-1:0] r_mem [0:(1<<AddrSize)-1];

  always_ff @(posedge Clk) begin
    if (i_we) begin
      for (int i = 0; i < BYTE_EN_SIZE; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    // Read data only updates on an access, so it stays stable while a response waits.
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Target end of the CPU memory request interface: one load/store at a time,
// with a programmable number of wait states before the array access.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DataSize   = DATA_SIZE,
  parameter int AddrSize   = 8,
  parameter int WaitStates = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReqWrite,
  input  logic [31:0]             ReqAddr,
  input  logic [DataSize-1:0]     ReqWData,
  input  logic [BYTE_EN_SIZE-1:0] ReqByteEn,
  output logic                    RespValid,
  input  logic                    RespReady,
  output logic [DataSize-1:0]     RespData,
  output logic                    RespError
);

  state_t                  r_state, w_state_next;
  logic [3:0]              r_cnt, w_cnt_next;
  logic                    r_write;
  logic [31:0]             r_addr;
  logic [DataSize-1:0]     r_wdata;
  logic [BYTE_EN_SIZE-1:0] r_be;
  logic                    r_resp_err;
  logic                    r_resp_load;
  logic                    w_err;
  logic                    w_we;
  logic                    w_re;
  logic [DataSize-1:0]     w_rdata;

  assign w_err = addr_error(r_addr, AddrSize);
  assign w_we  = (r_state == ST_ACCESS) &&  r_write && !w_err;
  assign w_re  = (r_state == ST_ACCESS) && !r_write && !w_err;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    ReqReady     = 1'b0;
    RespValid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (WaitStates == 0) begin
            w_state_next = ST_ACCESS;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = 4'(WaitStates - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_state_next = ST_ACCESS;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      ST_ACCESS: w_state_next = ST_RESP;
      ST_RESP: begin
        RespValid = 1'b1;
        if (RespReady) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_resp_err  <= 1'b0;
      r_resp_load <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == ST_ACCESS) begin
        r_resp_err  <= w_err;
        r_resp_load <= !r_write && !w_err;
      end else if (r_state == ST_RESP && RespReady) begin
        r_resp_err  <= 1'b0;
        r_resp_load <= 1'b0;
      end
    end
  end

  // Request fields are captured only on the accept edge; later changes are ignored.
  always_ff @(posedge Clk) begin
    if (r_state == ST_IDLE && ReqValid) begin
      r_write <= ReqWrite;
      r_addr  <= ReqAddr;
      r_wdata <= ReqWData;
      r_be    <= ReqByteEn;
    end
  end

  mem_array #(
    .DataW    (DataSize),
    .AddrSize (AddrSize)
  ) u_array (
    .Clk     (Clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr[AddrSize+1:2]),
    .i_be    (r_be),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign RespData  = r_resp_load ? w_rdata : '0;
  assign RespError = r_resp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of load/store vectors plus
// hand-written stall, back-to-back and reset-abort sequences.
module tb_mem_responder;

  localparam int WS = 2;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic [3:0]  ReqByteEn;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespData;
  logic        RespError;

  int tests = 0;
  int fails = 0;

  mem_responder #(.DataSize(32), .AddrSize(8), .WaitStates(WS)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWrite  (ReqWrite),
    .ReqAddr   (ReqAddr),
    .ReqWData  (ReqWData),
    .ReqByteEn (ReqByteEn),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .RespData  (RespData),
    .RespError (RespError)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait for RespValid after the accept edge; returns edges counted (bounded).
  task automatic wait_resp(output int lat);
    lat = 0;
    while (RespValid !== 1'b1 && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
    int lat;
    @(negedge Clk);
    chk({nm, "_rdy"}, {31'd0, ReqReady}, 32'd1);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqWData = d; ReqByteEn = be; RespReady = 1'b1;
    @(posedge Clk); #1;
    ReqValid = 1'b0; ReqAddr = 32'h0000_0000; ReqWData = 32'h5555_5555; ReqByteEn = 4'hF;
    wait_resp(lat);
    chk({nm, "_lat"}, lat, WS + 1);
    chk({nm, "_data"}, RespData, exp_d);
    chk({nm, "_err"}, {31'd0, RespError}, {31'd0, exp_e});
    @(posedge Clk); #1;
    chk({nm, "_done"}, {31'd0, RespValid}, 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0000, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,         4'b1111, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0400, 32'h9999_9999, 4'b1111, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'b1111, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_03FC, 32'h1122_3344, 4'b1010, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 32'h11A5_33A5, 1'b0};
    vecs[13] = '{1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'h0, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 4'b1111, 32'h0, 1'b0};

    Reset = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
    ReqByteEn = '0; RespReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_rdy", {31'd0, ReqReady}, 32'd1);
    chk("rst_vld", {31'd0, RespValid}, 32'd0);
    chk("rst_data", RespData, 32'd0);
    chk("rst_err", {31'd0, RespError}, 32'd0);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk); #1;
    chk("idle_rdy", {31'd0, ReqReady}, 32'd1);
    chk("idle_vld", {31'd0, RespValid}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      txn($sformatf("v%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          vecs[i].exp_data, vecs[i].exp_err);
    end

    // Stalled response, then ReqValid held high for a back-to-back request.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h0000_0010; ReqByteEn = 4'h0; RespReady = 1'b0;
    @(posedge Clk); #1;
    ReqAddr = 32'h0000_0000;
    wait_resp(lat);
    chk("stall_lat", lat, WS + 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("stall%0d_vld", k), {31'd0, RespValid}, 32'd1);
      chk($sformatf("stall%0d_data", k), RespData, 32'hDEAD_BEAA);
      chk($sformatf("stall%0d_err", k), {31'd0, RespError}, 32'd0);
      chk($sformatf("stall%0d_rdy", k), {31'd0, ReqReady}, 32'd0);
    end
    @(negedge Clk) RespReady = 1'b1;
    @(posedge Clk); #1;
    chk("hs_vld", {31'd0, RespValid}, 32'd0);
    chk("hs_rdy", {31'd0, ReqReady}, 32'd1);
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("b2b_busy", {31'd0, ReqReady}, 32'd0);
    wait_resp(lat);
    chk("b2b_lat", lat, WS + 1);
    chk("b2b_data", RespData, 32'hCAFE_F00D);
    @(posedge Clk); #1;
    chk("b2b_done", {31'd0, RespValid}, 32'd0);

    // Reset during the wait states of a store: the store must be discarded.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h0000_0020; ReqWData = 32'h2222_2222;
    ReqByteEn = 4'hF;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("rwait_rdy", {31'd0, ReqReady}, 32'd0);
    @(negedge Clk) Reset = 1'b0;
    #1;
    chk("rmid_rdy", {31'd0, ReqReady}, 32'd1);
    chk("rmid_vld", {31'd0, RespValid}, 32'd0);
    chk("rmid_data", RespData, 32'd0);
    chk("rmid_err", {31'd0, RespError}, 32'd0);
    @(negedge Clk) Reset = 1'b1;
    txn("rmid_load", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1111_1111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
